onecold_monitor: RTL
====================

ONECOLD_MONITOR -- requirements
Module: onecold_monitor

Interface
REQ-001 The block SHALL have parameter W, default 4, meaning width of the monitored vector (W >= 2).
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning width of the violation counter.
REQ-003 The block SHALL have parameter MAX_BAD, default 3, meaning consecutive violations that trip the alarm (1..255).
REQ-004 The block SHALL have port clk, input, 1, meaning the single clock; all state is updated on the rising edge.
REQ-005 The block SHALL have port rst_n, input, 1, meaning asynchronous active-low reset.
REQ-006 The block SHALL have port in_valid, input, 1, meaning in_vec is sampled this cycle.
REQ-007 The block SHALL have port in_vec, input, W, meaning the vector checked for the one-cold property.
REQ-008 The block SHALL have port clear, input, 1, meaning synchronous clear of counter, alarm and capture.
REQ-009 The block SHALL have port out_valid, output, 1, meaning the result outputs are valid.
REQ-010 The block SHALL have port is_onecold, output, 1, meaning the sampled vector had exactly one bit at 0.
REQ-011 The block SHALL have port zero_idx, output, $clog2(W), meaning the index of the single 0 bit.
REQ-012 The block SHALL have port viol_cnt, output, CNT_W, meaning the saturating count of non-one-cold samples.
REQ-013 The block SHALL have port alarm, output, 1, meaning the sticky consecutive-violation alarm.
REQ-014 The block SHALL have port first_bad_vec, output, W, meaning the first violating vector captured since reset or clear.
REQ-015 The block SHALL have port first_bad_valid, output, 1, meaning first_bad_vec holds a capture.

Function
REQ-016 The block SHALL register out_valid, is_onecold and zero_idx exactly 1 cycle after a sample with in_valid=1; out_valid SHALL be 0 in cycles following in_valid=0.
REQ-017 The block SHALL set is_onecold=1 iff in_vec contains exactly one 0 bit (equivalently, ~in_vec is one-hot).
REQ-018 The block SHALL drive zero_idx=0 whenever is_onecold=0.
REQ-019 The block SHALL increment viol_cnt by 1 on each valid non-one-cold sample and SHALL saturate it at 2^CNT_W-1 without wrapping.
REQ-020 The block SHALL, on the first valid violation while first_bad_valid=0, load first_bad_vec with in_vec and set first_bad_valid=1; later violations SHALL NOT overwrite it.
REQ-021 The block SHALL implement the FSM states OK, WARN and ALARM, with a run counter counting consecutive valid violations.
REQ-022 In OK, a valid violation SHALL set run=1 and go to WARN, or go directly to ALARM if MAX_BAD=1.
REQ-023 In WARN, a valid one-cold sample SHALL clear run and go to OK; a valid violation SHALL increment run and go to ALARM when run reaches MAX_BAD.
REQ-024 Cycles with in_valid=0 SHALL NOT change the FSM or run.
REQ-025 The ALARM state SHALL be sticky until clear or reset; alarm SHALL be 1 iff the state is ALARM, registered in the same cycle that the transition occurs.
REQ-026 The block SHALL give clear priority when clear=1: viol_cnt=0, run=0, state=OK, first_bad_valid=0, first_bad_vec=0.
REQ-027 A sample presented with clear=1 and in_valid=1 SHALL still produce out_valid, is_onecold and zero_idx, but SHALL NOT be counted or captured.

Reset
REQ-028 While rst_n=0, all outputs SHALL be 0 and the state SHALL be OK, independent of clk.
REQ-029 When rst_n is asserted mid-stream, the block SHALL discard any in-flight result; the first valid sample after release SHALL report 1 cycle later.

Verification
REQ-030 Scenario: with W=4, in_vec=4'b1011 valid -> next cycle out_valid=1, is_onecold=1, zero_idx=2, viol_cnt=0.
REQ-031 Scenario: 4'b1111, then 4'b0000, then 4'b0101 (all valid) -> is_onecold=0 each time; viol_cnt=3; first_bad_vec=4'b1111; alarm=1 one cycle after the third sample (MAX_BAD=3).
REQ-032 Scenario: sequence 4'b0011, 4'b1110, 4'b0011, 4'b0011 -> the run resets at 4'b1110; alarm stays 0; viol_cnt=3.
REQ-033 Scenario: with CNT_W=2, 5 valid violations -> viol_cnt reaches 3 and holds there.
REQ-034 Scenario: in ALARM, clear=1 together with valid 4'b1111 -> outputs report is_onecold=0; viol_cnt=0, alarm=0 and first_bad_valid=0 after the edge.
REQ-035 Scenario: 20 random vectors with in_valid=1, including gaps, plus rst_n pulsed low mid-run -> is_onecold matches the $onecold reference; all outputs are 0 during reset.

Source files
------------

// File: rtl/onecold_monitor.sv
// onecold_monitor
//   Watches a W-bit vector for the one-cold property (exactly one bit at 0).
//   Each valid sample is classified and reported one cycle later. Violations
//   are counted in a saturating counter, the first violating vector is
//   captured, and a run of MAX_BAD consecutive valid violations trips a
//   sticky alarm that only clear or reset can release.
//
// Ports
//   clk             rising-edge clock
//   rst_n           asynchronous active-low reset
//   in_valid        in_vec is sampled this cycle
//   in_vec[W-1:0]   vector under test
//   clear           synchronous clear of counter, alarm, run and capture
//   out_valid       result outputs valid (one cycle after in_valid)
//   is_onecold      sampled vector had exactly one 0 bit
//   zero_idx        index of the single 0 bit, 0 when is_onecold=0
//   viol_cnt        saturating count of valid violations
//   alarm           sticky consecutive-violation alarm
//   first_bad_vec   first violating vector since reset/clear
//   first_bad_valid first_bad_vec holds a capture
//
// FSM states
//   state    | meaning
//   ST_OK    | no open run of violations
//   ST_WARN  | 1..MAX_BAD-1 consecutive valid violations seen
//   ST_ALARM | MAX_BAD consecutive violations reached; sticky until clear

module onecold_monitor #(
    parameter int W       = 4,
    parameter int CNT_W   = 8,
    parameter int MAX_BAD = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [W-1:0]         in_vec,
    input  logic                 clear,
    output logic                 out_valid,
    output logic                 is_onecold,
    output logic [$clog2(W)-1:0] zero_idx,
    output logic [CNT_W-1:0]     viol_cnt,
    output logic                 alarm,
    output logic [W-1:0]         first_bad_vec,
    output logic                 first_bad_valid
);

    localparam int ZW    = $clog2(W);
    localparam int RUN_W = $clog2(MAX_BAD + 1);

    localparam logic [ZW:0]      ZCNT_ONE = (ZW + 1)'(1);
    localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
    localparam logic [RUN_W-1:0] RUN_TRIP = RUN_W'(MAX_BAD);

    typedef enum logic [1:0] {
        ST_OK    = 2'd0,
        ST_WARN  = 2'd1,
        ST_ALARM = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [RUN_W-1:0] run, run_nxt;

    logic [ZW:0]   zero_cnt;
    logic [ZW-1:0] zero_pos;
    logic          sample_oc;
    logic          count_en;

    // Count zero bits and remember where one sits; the position is only
    // meaningful when exactly one zero was found.
    always_comb begin
        zero_cnt = '0;
        zero_pos = '0;
        for (int i = 0; i < W; i++) begin
            if (!in_vec[i]) begin
                zero_cnt = zero_cnt + ZCNT_ONE;
                zero_pos = ZW'(i);
            end
        end
    end

    assign sample_oc = (zero_cnt == ZCNT_ONE);

    // A sample arriving together with clear is still reported but is not
    // allowed to count or capture.
    assign count_en = in_valid && !sample_oc && !clear;

    always_comb begin
        state_nxt = state;
        run_nxt   = run;
        if (clear) begin
            state_nxt = ST_OK;
            run_nxt   = '0;
        end else if (in_valid) begin
            unique case (state)
                ST_OK: begin
                    if (!sample_oc) begin
                        run_nxt   = RUN_ONE;
                        state_nxt = (MAX_BAD == 1) ? ST_ALARM : ST_WARN;
                    end
                end
                ST_WARN: begin
                    if (sample_oc) begin
                        run_nxt   = '0;
                        state_nxt = ST_OK;
                    end else begin
                        // run stays below MAX_BAD in WARN, so +1 cannot overflow
                        run_nxt = run + RUN_ONE;
                        if (run_nxt >= RUN_TRIP) begin
                            state_nxt = ST_ALARM;
                        end
                    end
                end
                ST_ALARM: begin
                    state_nxt = ST_ALARM;
                end
                default: begin
                    state_nxt = ST_OK;
                    run_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_OK;
            run   <= '0;
            alarm <= 1'b0;
        end else begin
            state <= state_nxt;
            run   <= run_nxt;
            alarm <= (state_nxt == ST_ALARM);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            is_onecold <= 1'b0;
            zero_idx   <= '0;
        end else begin
            out_valid  <= in_valid;
            is_onecold <= in_valid && sample_oc;
            zero_idx   <= (in_valid && sample_oc) ? zero_pos : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            viol_cnt        <= '0;
            first_bad_vec   <= '0;
            first_bad_valid <= 1'b0;
        end else if (clear) begin
            viol_cnt        <= '0;
            first_bad_vec   <= '0;
            first_bad_valid <= 1'b0;
        end else if (count_en) begin
            if (viol_cnt != {CNT_W{1'b1}}) begin
                viol_cnt <= viol_cnt + CNT_W'(1);
            end
            if (!first_bad_valid) begin
                first_bad_vec   <= in_vec;
                first_bad_valid <= 1'b1;
            end
        end
    end

endmodule
